// File: rtl/pcm_frame_packer.sv
// Packs little-endian 16-bit PCM samples popped byte-wise from the audio FIFO
// into transmit frames, keeping one frame staged. Option: PCM_PACKER_PARITY_EN.
module pcm_frame_packer #(
  parameter int PAD_HI_W = 2,
  parameter int TRAIL_W  = 2,
  parameter int UCNT_W   = 8,
  localparam int FRAME_W = PAD_HI_W + 16 + TRAIL_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               enable_in,
  input  logic               fifo_empty_in,
  input  logic [7:0]         fifo_dout_in,
  output logic               fifo_rd_en_out,
  input  logic               frame_req_in,
  output logic [FRAME_W-1:0] frame_out,
  output logic               staged_valid_out,
  output logic [UCNT_W-1:0]  underrun_cnt_out
);

  typedef enum logic [2:0] {
    IDLE, FETCH_LO, LATCH_LO, FETCH_HI, LATCH_HI, READY
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           lo_q;
  logic [FRAME_W-1:0]   staging;
  logic [15:0]          sample;
  logic [TRAIL_W-1:0]   trailer;
  logic                 serve;

  assign sample = {fifo_dout_in, lo_q};
  // Dropping enable discards the staged frame, so a request then is silence.
  assign serve  = (state == READY) && enable_in && frame_req_in;

  always_comb begin
    trailer = '0;
`ifdef PCM_PACKER_PARITY_EN
    trailer[0] = ^sample;
`endif
  end

  always_comb begin
    state_nxt      = state;
    fifo_rd_en_out = 1'b0;
    if (!enable_in) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = FETCH_LO;
        FETCH_LO: if (!fifo_empty_in) begin
                    fifo_rd_en_out = 1'b1;
                    state_nxt      = LATCH_LO;
                  end
        LATCH_LO: state_nxt = FETCH_HI;
        FETCH_HI: if (!fifo_empty_in) begin
                    fifo_rd_en_out = 1'b1;
                    state_nxt      = LATCH_HI;
                  end
        LATCH_HI: state_nxt = READY;
        READY:    if (frame_req_in) state_nxt = FETCH_LO;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      lo_q             <= '0;
      staging          <= '0;
      staged_valid_out <= 1'b0;
      frame_out        <= '0;
      underrun_cnt_out <= '0;
    end else begin
      state <= state_nxt;
      if (state == LATCH_LO && enable_in)
        lo_q <= fifo_dout_in;
      if (!enable_in) begin
        staged_valid_out <= 1'b0;
      end else if (state == LATCH_HI) begin
        staging          <= {{PAD_HI_W{1'b0}}, sample, trailer};
        staged_valid_out <= 1'b1;
      end else if (serve) begin
        staged_valid_out <= 1'b0;
      end
      // Any request outside READY is answered with silence and counted.
      if (frame_req_in) begin
        if (serve) begin
          frame_out <= staging;
        end else begin
          frame_out <= '0;
          if (underrun_cnt_out != {UCNT_W{1'b1}})
            underrun_cnt_out <= underrun_cnt_out + {{(UCNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Directed bench for pcm_frame_packer with a small byte-FIFO model.
module tb_pcm_frame_packer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        enable_in = 1'b0;
  logic        fifo_empty_in;
  logic [7:0]  fifo_dout_in = 8'h00;
  logic        fifo_rd_en_out;
  logic        frame_req_in = 1'b0;
  logic [19:0] frame_out;
  logic        staged_valid_out;
  logic [7:0]  underrun_cnt_out;

  logic [7:0]  mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_cnt = 0;
  int          viol = 0;
  logic        rd_prev = 1'b0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          base;

`ifdef PCM_PACKER_PARITY_EN
  localparam logic [19:0] EXP_T2 = 20'h048D1;
`else
  localparam logic [19:0] EXP_T2 = 20'h048D0;
`endif

  pcm_frame_packer dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
    .fifo_empty_in(fifo_empty_in), .fifo_dout_in(fifo_dout_in),
    .fifo_rd_en_out(fifo_rd_en_out), .frame_req_in(frame_req_in),
    .frame_out(frame_out), .staged_valid_out(staged_valid_out),
    .underrun_cnt_out(underrun_cnt_out)
  );

  always #20 clk_in = ~clk_in;

  assign fifo_empty_in = (rd_ptr == wr_ptr);

  // FIFO model: data valid one cycle after the pop; protocol violations tallied.
  always @(posedge clk_in) begin
    if (fifo_rd_en_out) begin
      if (fifo_empty_in) viol <= viol + 1;
      else begin
        fifo_dout_in <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1;
      end
      rd_cnt <= rd_cnt + 1;
    end
    if (fifo_rd_en_out && rd_prev) viol <= viol + 1;
    rd_prev <= fifo_rd_en_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic request();
    frame_req_in = 1'b1;
    tick();
    frame_req_in = 1'b0;
  endtask

  task automatic wait_rd(input int target, input string tag);
    int k = 0;
    while (rd_cnt < target && k < 50) begin
      tick();
      k++;
    end
    chk(tag, rd_cnt, target);
  endtask

  task automatic wait_staged(input string tag);
    int k = 0;
    while (!staged_valid_out && k < 30) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, staged_valid_out}, 1);
  endtask

  initial begin
    // reset state
    #5;
    chk("rst_frame", frame_out, 0);
    chk("rst_staged", staged_valid_out, 0);
    chk("rst_ucnt", underrun_cnt_out, 0);
    chk("rst_rden", fifo_rd_en_out, 0);
    tick();
    rst_in = 1'b0;
    tick();

    // basic frame 0x1234 and 5-cycle latency
    push(8'h34); push(8'h12);
    enable_in = 1'b1;
    repeat (4) tick();
    chk("lat_not_yet", staged_valid_out, 0);
    tick();
    chk("lat_ready", staged_valid_out, 1);
    request();
    chk("t2_frame", frame_out, EXP_T2);
    chk("t2_rdcnt", rd_cnt, 2);
    chk("t2_ucnt", underrun_cnt_out, 0);
    chk("t2_staged_clr", staged_valid_out, 0);

    // request coincident with LATCH_HI is an underrun; frame stays staged
    push(8'h78); push(8'h56);
    base = rd_cnt;
    wait_rd(base + 2, "t6_pops");
    request();
    chk("t6_ucnt", underrun_cnt_out, 1);
    chk("t6_frame_sil", frame_out, 0);
    chk("t6_staged", staged_valid_out, 1);
    request();
    chk("t6_frame", frame_out, 20'h159E0);
    chk("t6_ucnt_hold", underrun_cnt_out, 1);

    // async reset in the middle of a FETCH_HI stall
    push(8'h11);
    base = rd_cnt;
    wait_rd(base + 1, "t1_pop_lo");
    tick();
    #2 rst_in = 1'b1; enable_in = 1'b0;
    #1;
    chk("t1_frame", frame_out, 0);
    chk("t1_staged", staged_valid_out, 0);
    chk("t1_ucnt", underrun_cnt_out, 0);
    chk("t1_rden", fifo_rd_en_out, 0);
    chk("t1_state", 32'(dut.state), 0);
    #5 rst_in = 1'b0;
    tick();
    chk("t1_state_idle", 32'(dut.state), 0);

    // empty FIFO: every request is silence, counter saturates
    enable_in = 1'b1;
    tick();
    base = rd_cnt;
    repeat (255) begin request(); tick(); end
    chk("t3_ucnt_255", underrun_cnt_out, 255);
    repeat (45) begin request(); tick(); end
    chk("t3_ucnt_sat", underrun_cnt_out, 255);
    chk("t3_frame", frame_out, 0);
    chk("t3_no_rd", rd_cnt, base);

    // stall between low and high byte
    push(8'hCD);
    base = rd_cnt;
    wait_rd(base + 1, "t4_pop_lo");
    tick();
    repeat (10) tick();
    chk("t4_stall_rdcnt", rd_cnt, base + 1);
    chk("t4_stall_rden", fifo_rd_en_out, 0);
    push(8'hAB);
    wait_staged("t4_staged");
    request();
    chk("t4_frame", frame_out, 20'h2AF34);

    // enable dropped in LATCH_LO discards the low byte
    push(8'h99);
    base = rd_cnt;
    wait_rd(base + 1, "t5_pop_lo");
    enable_in = 1'b0;
    tick();
    chk("t5_staged", staged_valid_out, 0);
    chk("t5_frame_hold", frame_out, 20'h2AF34);
    chk("t5_rden", fifo_rd_en_out, 0);
    push(8'h02); push(8'h01);
    tick();
    enable_in = 1'b1;
    wait_staged("t5_staged2");
    request();
    chk("t5_frame", frame_out, 20'h00408);
    chk("t5_rdcnt", rd_cnt, base + 3);

    chk("rd_protocol", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
